// File: rtl/button_direction_ctrl.sv
// Button conditioning for the snake game: per-button synchroniser, debounce and
// press-pulse generation, plus the heading register that refuses 180-degree turns.
module button_direction_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_WIDTH       = 20
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       BTN_LEFT,
    input  logic       BTN_RIGHT,
    input  logic       BTN_UP,
    input  logic       BTN_DOWN,
    output logic       LEFT,
    output logic       RIGHT,
    output logic       UP,
    output logic       DOWN,
    output logic [1:0] DIRECTION
);

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    // Channel index matches the heading encoding: 0 UP, 1 RIGHT, 2 DOWN, 3 LEFT.
    logic [3:0]           raw;
    logic [3:0]           sync1;
    logic [3:0]           sync2;
    logic [3:0]           level;
    logic [3:0]           level_q;
    logic [3:0]           pulse;
    logic [CNT_WIDTH-1:0] cnt [4];
    dir_t                 dir;

    assign raw = {BTN_LEFT, BTN_DOWN, BTN_RIGHT, BTN_UP};

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            level <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] >= CNT_LAST) begin
                    level[i] <= sync2[i];
                    cnt[i]   <= '0;
                end else if (cnt[i] != CNT_MAX) begin
                    cnt[i] <= cnt[i] + CNT_ONE;
                end
            end
        end
    end

    // Rising edge of the debounced level only; releases are silent.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            level_q <= '0;
            pulse   <= '0;
        end else begin
            level_q <= level;
            pulse   <= level & ~level_q;
        end
    end

    // Priority UP > RIGHT > DOWN > LEFT; the first pulse that is not a reversal wins.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            dir <= DIR_RIGHT;
        end else begin
            if (pulse[0] && dir != DIR_DOWN) begin
                dir <= DIR_UP;
            end else if (pulse[1] && dir != DIR_LEFT) begin
                dir <= DIR_RIGHT;
            end else if (pulse[2] && dir != DIR_UP) begin
                dir <= DIR_DOWN;
            end else if (pulse[3] && dir != DIR_RIGHT) begin
                dir <= DIR_LEFT;
            end
        end
    end

    assign UP        = pulse[0];
    assign RIGHT     = pulse[1];
    assign DOWN      = pulse[2];
    assign LEFT      = pulse[3];
    assign DIRECTION = dir;

endmodule

// File: doc/button_direction_ctrl.md
# button_direction_ctrl

Conditions the four raw push-button inputs (left, right, up, down) for the snake game and drives both the master state machine and the snake movement logic. Each button is synchronised, debounced and converted to a single-cycle press pulse; the pulses feed the LEFT/RIGHT/UP/DOWN inputs of `master_sm`. A direction register holds the snake's current heading and rejects 180° reversals.

## Interface
- DEBOUNCE_CYCLES, default 1000000: consecutive stable cycles required before a level change is accepted (10 ms at 100 MHz); minimum 2.
- CNT_WIDTH, default 20: debounce counter width; must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES.

Ports:
- CLK  input  1  system clock; all logic is on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- BTN_LEFT  input  1  raw button input, asynchronous to CLK, active-high.
- BTN_RIGHT  input  1  raw button input, asynchronous to CLK, active-high.
- BTN_UP  input  1  raw button input, asynchronous to CLK, active-high.
- BTN_DOWN  input  1  raw button input, asynchronous to CLK, active-high.
- LEFT  output  1  registered one-cycle press pulse to master_sm.
- RIGHT  output  1  registered one-cycle press pulse to master_sm.
- UP  output  1  registered one-cycle press pulse to master_sm.
- DOWN  output  1  registered one-cycle press pulse to master_sm.
- DIRECTION  output  2  current heading: 00 UP, 01 RIGHT, 10 DOWN, 11 LEFT.

## Operation
- Per-button channel: 2-flop synchroniser → debounce counter → debounced level register → rising-edge pulse register.
- Debounce:
  - Counter clears whenever the synchronised input equals the debounced level.
  - Otherwise it increments by 1.
  - When it reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level takes the synchronised value and the counter clears.
  - Any bounce before that restarts the count.
  - The counter saturates and never wraps.
- Pulse: asserted for exactly one cycle on each debounced 0→1 transition. Release (1→0) produces no pulse. Holding a button produces a single pulse.
- Direction FSM has four states (UP, RIGHT, DOWN, LEFT). Next state on a pulse:
  - Pulse for a perpendicular direction: move to that direction.
  - Pulse for the current direction: no change.
  - Pulse for the opposite direction (UP↔DOWN, LEFT↔RIGHT): ignored.
- Simultaneous pulses in one cycle: evaluate in priority order UP > RIGHT > DOWN > LEFT and act on the highest-priority pulse that is not a reversal. If none qualifies, hold. All asserted pulse outputs still appear on LEFT/RIGHT/UP/DOWN unfiltered.
- The FSM does not depend on master_sm state; master_sm decides whether pulses matter.

## Timing
- Reset values, applied asynchronously:
  - Synchronisers, counters, debounced levels: 0.
  - LEFT/RIGHT/UP/DOWN: 0.
  - DIRECTION: 01 (RIGHT).
- Reset mid-debounce or mid-pulse: all progress is discarded. A button held through reset release needs a full synchroniser plus DEBOUNCE_CYCLES stable period, then pulses once.
- Latency, with a raw input going high and staying stable, first sampled at edge k:
  - Synchronised high after edge k+1.
  - Debounced level high after edge k+1+DEBOUNCE_CYCLES.
  - Pulse output high for the cycle after edge k+2+DEBOUNCE_CYCLES, low again after the following edge.
  - DIRECTION updates on the edge that ends the pulse cycle, i.e. one cycle after the pulse is first visible.
- Release latency (debounced level low) equals press latency. No output pulse on release.
- Minimum spacing between two pulses from the same button is 2·DEBOUNCE_CYCLES cycles.

## Test plan
- Reset with DEBOUNCE_CYCLES=4, all buttons low → all pulses 0, DIRECTION=01; asserting RESET mid-run returns DIRECTION to 01 immediately, without waiting for a CLK edge.
- BTN_UP held high for 20 cycles → UP high for exactly one cycle, 6 cycles after the first sampling edge; DIRECTION 01→00 one cycle later; no further pulses while held.
- BTN_LEFT toggled every 2 cycles for 20 cycles, then held → no pulse during the bouncing; one LEFT pulse after the stable period. DIRECTION stays 01 (reversal from RIGHT).
- From DIRECTION=00: BTN_DOWN press → DOWN pulse emitted, DIRECTION stays 00; then BTN_LEFT press → DIRECTION=11.
- From DIRECTION=01: BTN_UP and BTN_DOWN rise on the same edge → UP and DOWN pulse in the same cycle, DIRECTION=00 (priority).
- From DIRECTION=01: BTN_LEFT and BTN_UP rise on the same edge → DIRECTION=00. From DIRECTION=00: BTN_DOWN alone → DIRECTION unchanged.
